// File: rtl/pcileech_com_rxpack.sv
// Packs RATIO narrow input words into one wide word, with a double-SYNC_WORD
// resync, an optional idle timeout for partial words and a small FWFT output FIFO.
module pcileech_com_rxpack #(
  parameter int          DW_IN     = 32,
  parameter int          RATIO     = 2,
  parameter logic [31:0] SYNC_WORD = 32'h66665555,
  parameter int          DEPTH     = 4,
  parameter int          TIMEOUT   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DW_IN-1:0]            din,
  input  logic                        din_valid,
  output logic [DW_IN*RATIO-1:0]      dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic [$clog2(RATIO)-1:0]    lane,
  output logic                        resync_pulse,
  output logic                        timeout_pulse,
  output logic [15:0]                 drop_cnt
);

  localparam int OW = DW_IN * RATIO;
  localparam int LW = $clog2(RATIO);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DW_IN-1:0] SYNC_W = DW_IN'(SYNC_WORD);

  logic [OW-1:0]    pack_q, pack_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [DW_IN-1:0] last_word_q, last_word_d;
  logic             last_valid_q, last_valid_d;
  logic [CW-1:0]    idle_q, idle_d;
  logic             push_q, push_d;
  logic             resync_q, resync_d;
  logic             tmo_q, tmo_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [15:0]      drop_q, drop_d;
  logic [OW-1:0]    mem_q [DEPTH];

  logic resync, pop, full, wr_en;

  // A resync needs two consecutive markers; last_word is frozen across a resync
  // so a run of markers keeps resyncing.
  assign resync = din_valid && (din == SYNC_W) && last_valid_q && (last_word_q == SYNC_W);

  always_comb begin
    pack_d       = pack_q;
    lane_d       = lane_q;
    last_word_d  = last_word_q;
    last_valid_d = last_valid_q;
    idle_d       = idle_q;
    push_d       = 1'b0;
    resync_d     = 1'b0;
    tmo_d        = 1'b0;
    if (din_valid) begin
      idle_d = '0;
      if (resync) begin
        lane_d   = '0;
        pack_d   = '0;
        resync_d = 1'b1;
      end else begin
        pack_d       = {pack_q[OW-DW_IN-1:0], din};
        last_word_d  = din;
        last_valid_d = 1'b1;
        if (lane_q == LW'(RATIO - 1)) begin
          lane_d = '0;
          push_d = 1'b1;
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
    end else if ((TIMEOUT > 0) && (lane_q != '0)) begin
      if (idle_q == CW'(TIMEOUT - 1)) begin
        lane_d       = '0;
        pack_d       = '0;
        last_valid_d = 1'b0;
        idle_d       = '0;
        tmo_d        = 1'b1;
      end else begin
        idle_d = idle_q + CW'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  // The completed word stays in pack_q for the cycle after completion, which is
  // exactly when push_q writes it into the FIFO.
  assign dout_valid = (level_q != '0);
  assign pop        = dout_valid && dout_ready;
  assign full       = (level_q == (AW+1)'(DEPTH));
  assign wr_en      = push_q && (!full || pop) && !rst;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!wr_en && pop) level_d = level_q - (AW+1)'(1);
    drop_d = drop_q;
    if (push_q && full && !pop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q       <= '0;
      lane_q       <= '0;
      last_word_q  <= '0;
      last_valid_q <= 1'b0;
      idle_q       <= '0;
      push_q       <= 1'b0;
      resync_q     <= 1'b0;
      tmo_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= '0;
    end else begin
      pack_q       <= pack_d;
      lane_q       <= lane_d;
      last_word_q  <= last_word_d;
      last_valid_q <= last_valid_d;
      idle_q       <= idle_d;
      push_q       <= push_d;
      resync_q     <= resync_d;
      tmo_q        <= tmo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pack_q;
  end

  assign dout          = dout_valid ? mem_q[rd_ptr_q] : '0;
  assign level         = level_q;
  assign lane          = lane_q;
  assign resync_pulse  = resync_q;
  assign timeout_pulse = tmo_q;
  assign drop_cnt      = drop_q;

endmodule
